// File: rtl/des_round_ctrl.sv
// Round sequencer for the iterative DES datapath: issues load/round/final strobes and the host handshake.
// Optional abort input is enabled with `define DES_ROUND_CTRL_ABORT_EN.
module des_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 16,
    parameter logic [15:0] SHIFT_MAP  = 16'h8103
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       decrypt,
`ifdef DES_ROUND_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       load_en,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic [1:0] shift_amt,
    output logic       shift_dir,
    output logic       final_en,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int unsigned RW = 4;
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic          mode_q, mode_d;

    logic          busy_d, load_en_d, round_en_d, final_en_d, out_valid_d;
    logic [RW-1:0] round_idx_d;
    logic [1:0]    shift_amt_d;
    logic [RW-1:0] dec_pos;

    // State, counter, mode and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rnd_q     <= '0;
            mode_q    <= 1'b0;
            busy      <= 1'b0;
            load_en   <= 1'b0;
            round_en  <= 1'b0;
            round_idx <= '0;
            shift_amt <= '0;
            shift_dir <= 1'b0;
            final_en  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            mode_q    <= mode_d;
            busy      <= busy_d;
            load_en   <= load_en_d;
            round_en  <= round_en_d;
            round_idx <= round_idx_d;
            shift_amt <= shift_amt_d;
            shift_dir <= mode_d;
            final_en  <= final_en_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state and round counter
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    mode_d  = decrypt;
                end
            end
            S_LOAD: begin
                state_d = S_ROUND;
                rnd_d   = '0;
            end
            S_ROUND: begin
                if (rnd_q == LAST_ROUND) begin
                    state_d = S_FINAL;
                    rnd_d   = '0;
                end else begin
                    rnd_d = rnd_q + RW'(1);
                end
            end
            S_FINAL: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rnd_d   = '0;
            end
        endcase
`ifdef DES_ROUND_CTRL_ABORT_EN
        // Abort wins over the normal transition while the block is in flight
        if (abort && (state_q == S_LOAD || state_q == S_ROUND || state_q == S_FINAL)) begin
            state_d = S_IDLE;
            rnd_d   = '0;
        end
`endif
    end

    // Output decode from next state so every strobe lands in its own state's cycle
    always_comb begin
        busy_d      = 1'b0;
        load_en_d   = 1'b0;
        round_en_d  = 1'b0;
        final_en_d  = 1'b0;
        out_valid_d = 1'b0;
        round_idx_d = '0;
        shift_amt_d = '0;
        dec_pos     = RW'(NUM_ROUNDS - 32'(rnd_d));
        case (state_d)
            S_LOAD: begin
                busy_d    = 1'b1;
                load_en_d = 1'b1;
            end
            S_ROUND: begin
                busy_d      = 1'b1;
                round_en_d  = 1'b1;
                round_idx_d = rnd_d;
                // Decrypt walks the schedule backwards; round 0 uses the unrotated key
                if (!mode_d)
                    shift_amt_d = SHIFT_MAP[rnd_d] ? 2'd1 : 2'd2;
                else if (rnd_d == '0)
                    shift_amt_d = 2'd0;
                else
                    shift_amt_d = SHIFT_MAP[dec_pos] ? 2'd1 : 2'd2;
            end
            S_FINAL: begin
                busy_d     = 1'b1;
                final_en_d = 1'b1;
            end
            S_DONE: begin
                busy_d      = 1'b1;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboard bench for des_round_ctrl: stimulus queues expected strobes, a monitor checks them.
module tb_des_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, decrypt, out_ready;
    logic       busy, load_en, round_en, shift_dir, final_en, out_valid;
    logic [3:0] round_idx;
    logic [1:0] shift_amt;
`ifdef DES_ROUND_CTRL_ABORT_EN
    logic       abort;
`endif

    des_round_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt),
`ifdef DES_ROUND_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .load_en(load_en), .round_en(round_en), .round_idx(round_idx),
        .shift_amt(shift_amt), .shift_dir(shift_dir), .final_en(final_en),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] kind;   // {load, round, final, valid}
        int         idx;
        int         amt;
        int         dir;
        int         cyc;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    logic prev_valid = 1'b0;

    int enc_amt [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int dec_amt [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe or rising out_valid consumes one scoreboard entry
    always @(negedge clk) begin
        logic [3:0] kind;
        ev_t        e;
        if (rst_n) begin
            kind = {load_en, round_en, final_en, out_valid && !prev_valid};
            check("strobe_excl", 32'($countones({load_en, round_en, final_en}) <= 1), 32'd1);
            if (kind != 4'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual=%b expected=none at cycle %0d", kind, cyc);
                end else begin
                    e = sb.pop_front();
                    check("kind", 32'(kind), 32'(e.kind));
                    check("round_idx", 32'(round_idx), e.idx);
                    check("shift_amt", 32'(shift_amt), e.amt);
                    check("shift_dir", 32'(shift_dir), e.dir);
                    check("cycle", cyc, e.cyc);
                end
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic push(input logic [3:0] k, input int idx, input int amt, input int dir, input int c);
        ev_t e;
        e.kind = k; e.idx = idx; e.amt = amt; e.dir = dir; e.cyc = c;
        sb.push_back(e);
    endtask

    // Called at a negedge; start is sampled on the following posedge
    task automatic issue(input logic dec);
        int t;
        t = cyc;
        start   = 1'b1;
        decrypt = dec;
        push(4'b1000, 0, 0, int'(dec), t + 1);
        for (int i = 0; i < 16; i++)
            push(4'b0100, i, dec ? dec_amt[i] : enc_amt[i], int'(dec), t + 2 + i);
        push(4'b0010, 0, 0, int'(dec), t + 18);
        push(4'b0001, 0, 0, int'(dec), t + 19);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid actual=timeout expected=out_valid at cycle %0d", cyc);
        end
    endtask

    task automatic wait_round(input int k);
        int n = 0;
        while (!(round_en && int'(round_idx) == k) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(round_en && int'(round_idx) == k)) begin
            checks++;
            errors++;
            $display("FAIL wait_round actual=timeout expected=round %0d at cycle %0d", k, cyc);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_load"}, 32'(load_en), 32'd0);
        check({tag, "_round"}, 32'(round_en), 32'd0);
        check({tag, "_idx"}, 32'(round_idx), 32'd0);
        check({tag, "_amt"}, 32'(shift_amt), 32'd0);
        check({tag, "_dir"}, 32'(shift_dir), 32'd0);
        check({tag, "_final"}, 32'(final_en), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; out_ready = 1'b0;
`ifdef DES_ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Encrypt block
        issue(1'b0);
        wait_valid();
        check("enc_busy_done", 32'(busy), 32'd1);
        handshake();

        // Decrypt block with decrypt toggling mid-block
        issue(1'b1);
        for (int i = 0; i < 12; i++) begin
            decrypt = ~decrypt;
            @(negedge clk);
        end
        decrypt = 1'b0;
        wait_valid();
        check("dec_dir_done", 32'(shift_dir), 32'd1);
        handshake();

        // Backpressure
        issue(1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        handshake();

        // Start while busy and during the DONE handshake
        issue(1'b0);
        wait_round(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid();
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        check("hs_start_load", 32'(load_en), 32'd0);
        check("hs_start_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        issue(1'b1);
        wait_valid();
        handshake();

        // Reset mid-operation
        issue(1'b0);
        wait_round(7);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("midrst_no_valid", 32'(out_valid), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        issue(1'b0);
        wait_valid();
        handshake();

`ifdef DES_ROUND_CTRL_ABORT_EN
        // Abort during rounds
        issue(1'b0);
        wait_round(3);
        abort = 1'b1;
        @(posedge clk);
        #1 sb.delete();
        @(negedge clk);
        abort = 1'b0;
        check("abort_round_en", 32'(round_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_final", 32'(final_en), 32'd0);
        repeat (25) @(negedge clk);
        check("abort_no_valid", 32'(out_valid), 32'd0);
        issue(1'b1);
        wait_valid();
        handshake();
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
